// File: rtl/moxie_wb_pkg.sv
// ============================================================================
// moxie_wb_pkg : shared Wishbone-slave state encoding, lane and counter constants
// Revision     : 1.0
// ============================================================================
`default_nettype none

package moxie_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    localparam logic [1:0] SEL_LO = 2'b01;
    localparam logic [1:0] SEL_HI = 2'b10;
    localparam logic [1:0] SEL_HW = 2'b11;

    localparam int WAIT_CNT_W = 3;

endpackage

`default_nettype wire

// File: rtl/dmem_ram16.sv
// ============================================================================
// dmem_ram16 : single-port 2^ADDR_WIDTH x 16 RAM, byte-lane write enables,
//              synchronous read returning the pre-write contents
// Revision   : 1.0
// ============================================================================
`default_nettype none

module dmem_ram16 #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [1:0]            sel_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [15:0]           wdata_i,
    output logic [15:0]           rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Each byte lane owns its own storage array so lane writes never overlap.
    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [7:0] r_mem [0:DEPTH-1];
        logic [7:0] r_rd;

        always_ff @(posedge clk_i) begin
            if (en_i) begin
                r_rd <= r_mem[addr_i];
                if (we_i && sel_i[g]) begin
                    r_mem[addr_i] <= wdata_i[8*g +: 8];
                end
            end
        end

        assign rdata_o[8*g +: 8] = r_rd;
    end

endmodule

`default_nettype wire

// File: rtl/dmem_wb_slave.sv
// ============================================================================
// dmem_wb_slave : Wishbone classic slave fronting a 16-bit two-lane data RAM,
//                 with WAIT_STATES wait cycles and single-cycle ack/err pulses.
//                 Define MOXIE_DMEM_ERR_EN to enable out-of-range err responses.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module dmem_wb_slave
    import moxie_wb_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam logic [WAIT_CNT_W-1:0] C_WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] C_WAIT_ONE  = WAIT_CNT_W'(1);

    wb_state_t              r_state;
    logic [WAIT_CNT_W-1:0]  r_cnt;
    logic [31:0]            r_adr;
    logic [15:0]            r_dat;
    logic [1:0]             r_sel;
    logic                   r_we;
    logic                   r_ack;

    logic                   w_req;
    logic                   w_go_resp;
    logic                   w_fire;
    logic [31:0]            w_adr;
    logic [15:0]            w_dat;
    logic [1:0]             w_sel;
    logic                   w_we;
    logic [31:0]            w_off;
    logic                   w_in_range;
    logic [15:0]            w_rdata;
    logic                   w_unused_bits;

    assign w_req = wb_cyc_i & wb_stb_i;

    // The RAM is accessed on the edge that enters RESP; with no wait states
    // that is the sampling edge itself, so the bus inputs feed the RAM directly.
    assign w_go_resp = ((r_state == IDLE) && w_req && (WAIT_STATES == 0)) ||
                       ((r_state == WAIT) && wb_cyc_i && (r_cnt == C_WAIT_ONE));
    assign w_fire    = w_go_resp & ~rst_i;

    assign w_adr = (r_state == IDLE) ? wb_adr_i : r_adr;
    assign w_dat = (r_state == IDLE) ? wb_dat_i : r_dat;
    assign w_sel = (r_state == IDLE) ? wb_sel_i : r_sel;
    assign w_we  = (r_state == IDLE) ? wb_we_i  : r_we;

    assign w_off = w_adr - BASE_ADDR;

`ifdef MOXIE_DMEM_ERR_EN
    assign w_in_range = (w_off[31:ADDR_WIDTH+1] == '0);
`else
    assign w_in_range = 1'b1;
`endif

    assign w_unused_bits = ^{w_off[31:ADDR_WIDTH+1], w_off[0]};

    dmem_ram16 #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (w_fire),
        .we_i    (w_we & w_in_range),
        .sel_i   (w_sel),
        .addr_i  (w_off[ADDR_WIDTH:1]),
        .wdata_i (w_dat),
        .rdata_o (w_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_ack <= w_go_resp & w_in_range;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_adr <= wb_adr_i;
                        r_dat <= wb_dat_i;
                        r_sel <= wb_sel_i;
                        r_we  <= wb_we_i;
                        r_cnt <= C_WAIT_LOAD;
                        r_state <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!wb_cyc_i) begin
                        r_state <= IDLE;
                    end else if (r_cnt == C_WAIT_ONE) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - C_WAIT_ONE;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef MOXIE_DMEM_ERR_EN
    logic r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_go_resp & ~w_in_range;
        end
    end

    assign wb_err_o = r_err;
`else
    assign wb_err_o = 1'b0;
`endif

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_ack ? w_rdata : 16'h0000;

endmodule

`default_nettype wire

// File: tb/tb_dmem_wb_slave.sv
// ============================================================================
// tb_dmem_wb_slave : self-checking bench for dmem_wb_slave at WAIT_STATES 1/0/3
// Revision         : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_wb_slave;
    import moxie_wb_pkg::*;

    localparam int AW = 12;
    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst  [ND];
    logic [31:0] adr  [ND];
    logic [15:0] wdat [ND];
    logic [1:0]  sel  [ND];
    logic        stb  [ND];
    logic        cyc  [ND];
    logic        we   [ND];
    logic [15:0] rdat [ND];
    logic        ack  [ND];
    logic        err  [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dmem_wb_slave #(
            .ADDR_WIDTH  (AW),
            .WAIT_STATES ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .BASE_ADDR   (32'h0000_0000)
        ) u_dut (
            .clk_i    (clk),
            .rst_i    (rst[g]),
            .wb_adr_i (adr[g]),
            .wb_dat_i (wdat[g]),
            .wb_dat_o (rdat[g]),
            .wb_sel_i (sel[g]),
            .wb_stb_i (stb[g]),
            .wb_cyc_i (cyc[g]),
            .wb_we_i  (we[g]),
            .wb_ack_o (ack[g]),
            .wb_err_o (err[g])
        );
    end

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] mem_m [ND][1 << AW];

    function automatic int ws_of(int d);
        case (d)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic bit in_rng(logic [31:0] a);
`ifdef MOXIE_DMEM_ERR_EN
        return a < 32'h0000_2000;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a >> 1) % (1 << AW));
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(int d, logic [31:0] a, logic [15:0] wd, logic [1:0] s);
        if (in_rng(a)) begin
            if (s[0]) mem_m[d][widx(a)][7:0]  = wd[7:0];
            if (s[1]) mem_m[d][widx(a)][15:8] = wd[15:8];
        end
    endtask

    // One complete classic-cycle transfer; checks latency and single-cycle pulse.
    task automatic xfer(int d, logic w, logic [31:0] a, logic [15:0] wd, logic [1:0] s,
                        output logic [15:0] rd, output logic er);
        int k;
        adr[d] = a; wdat[d] = wd; sel[d] = s; we[d] = w;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
        end while (!ack[d] && !err[d] && k < 20);
        check($sformatf("latency dut%0d adr %h", d, a), k, ws_of(d) + 1);
        rd = rdat[d];
        er = err[d];
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        tick();
        check($sformatf("pulse end dut%0d", d), {ack[d], err[d], rdat[d]}, 32'h0);
    endtask

    task automatic txn(int d, logic w, logic [31:0] a, logic [15:0] wd, logic [1:0] s, string nm);
        logic [15:0] rd;
        logic        er;
        bit          ok;
        ok = in_rng(a);
        xfer(d, w, a, wd, s, rd, er);
        check({nm, " err"}, {31'h0, er}, {31'h0, ~ok});
        if (!w) check({nm, " data"}, {16'h0, rd}, {16'h0, ok ? mem_m[d][widx(a)] : 16'h0000});
        if (w) model_write(d, a, wd, s);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [15:0] wd;
        logic [1:0]  s;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd;
        logic        er;
        logic        seen;
        logic [31:0] a;

        for (int d = 0; d < ND; d++) begin
            rst[d] = 1'b1; adr[d] = '0; wdat[d] = '0; sel[d] = '0;
            stb[d] = 1'b0; cyc[d] = 1'b0; we[d] = 1'b0;
        end
        tick(); tick(); tick();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset outputs dut%0d", d), {ack[d], err[d], rdat[d]}, 32'h0);
            rst[d] = 1'b0;
        end

        tbl[0] = '{1'b1, 32'h10, 16'hBEEF, SEL_HW, 16'h0000};
        tbl[1] = '{1'b0, 32'h10, 16'h0000, SEL_HW, 16'hBEEF};
        tbl[2] = '{1'b1, 32'h20, 16'h1234, SEL_HW, 16'h0000};
        tbl[3] = '{1'b1, 32'h20, 16'h00AB, SEL_LO, 16'h0000};
        tbl[4] = '{1'b0, 32'h20, 16'h0000, SEL_LO, 16'h12AB};
        tbl[5] = '{1'b1, 32'h20, 16'hCD00, SEL_HI, 16'h0000};
        tbl[6] = '{1'b0, 32'h21, 16'h0000, 2'b00,  16'hCDAB};
        tbl[7] = '{1'b1, 32'h22, 16'h5A5A, SEL_HW, 16'h0000};
        tbl[8] = '{1'b1, 32'h22, 16'hFFFF, 2'b00,  16'h0000};
        tbl[9] = '{1'b0, 32'h22, 16'h0000, SEL_HW, 16'h5A5A};

        for (int i = 0; i < 10; i++) begin
            xfer(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].s, rd, er);
            check($sformatf("table %0d err", i), {31'h0, er}, 32'h0);
            if (!tbl[i].w) check($sformatf("table %0d data", i), {16'h0, rd}, {16'h0, tbl[i].exp});
            if (tbl[i].w) model_write(0, tbl[i].a, tbl[i].wd, tbl[i].s);
        end

        // Address one past the RAM: err with the range check, alias of 0 without.
        txn(0, 1'b1, 32'h0, 16'hA5A5, SEL_HW, "alias prep");
        xfer(0, 1'b0, 32'h2000, 16'h0, SEL_HW, rd, er);
`ifdef MOXIE_DMEM_ERR_EN
        check("out-of-range err", {31'h0, er}, 32'h1);
        check("out-of-range data", {16'h0, rd}, 32'h0);
`else
        check("alias err", {31'h0, er}, 32'h0);
        check("alias data", {16'h0, rd}, 32'h0000_A5A5);
`endif

        // Back-to-back reads with strobe held high, zero wait states.
        txn(1, 1'b1, 32'h60, 16'h1357, SEL_HW, "b2b prep");
        adr[1] = 32'h60; we[1] = 1'b0; sel[1] = SEL_HW; cyc[1] = 1'b1; stb[1] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("b2b ack cycle %0d", i), {31'h0, ack[1]}, i % 2);
            if (ack[1]) check($sformatf("b2b data cycle %0d", i), {16'h0, rdat[1]}, 32'h0000_1357);
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        tick();

        // Abort: drop cyc one cycle into a three-wait-state write.
        txn(2, 1'b1, 32'h30, 16'h0000, SEL_HW, "abort prep");
        adr[2] = 32'h30; wdat[2] = 16'h5555; sel[2] = SEL_HW; we[2] = 1'b1;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        tick();
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | ack[2] | err[2];
        end
        check("abort no ack", {31'h0, seen}, 32'h0);
        txn(2, 1'b0, 32'h30, 16'h0, SEL_HW, "abort readback");

        // Reset while in WAIT drops the pending write.
        txn(0, 1'b1, 32'h40, 16'h1111, SEL_HW, "rst-wait prep");
        adr[0] = 32'h40; wdat[0] = 16'h2222; sel[0] = SEL_HW; we[0] = 1'b1;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        tick();
        rst[0] = 1'b1;
        tick();
        check("rst-wait outputs", {ack[0], err[0], rdat[0]}, 32'h0);
        rst[0] = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        tick();
        txn(0, 1'b0, 32'h40, 16'h0, SEL_HW, "rst-wait readback");

        // Reset coincident with a request: the request is never latched.
        txn(1, 1'b1, 32'h50, 16'h2468, SEL_HW, "rst-req prep");
        adr[1] = 32'h50; wdat[1] = 16'hFFFF; sel[1] = SEL_HW; we[1] = 1'b1;
        cyc[1] = 1'b1; stb[1] = 1'b1; rst[1] = 1'b1;
        tick();
        check("rst-req no ack", {ack[1], err[1], rdat[1]}, 32'h0);
        rst[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        tick();
        check("rst-req still idle", {ack[1], err[1], rdat[1]}, 32'h0);
        txn(1, 1'b0, 32'h50, 16'h0, SEL_HW, "rst-req readback");

        // Randomized traffic against the reference model on every instance.
        for (int d = 0; d < ND; d++) begin
            for (int i = 0; i < 32; i++) begin
                txn(d, 1'b1, 32'(2 * i), 16'($urandom), SEL_HW, $sformatf("init d%0d", d));
            end
            for (int i = 0; i < 80; i++) begin
                a = 32'(2 * $urandom_range(0, 31) + $urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) a = a | (32'($urandom_range(1, 7)) << 13);
                txn(d, 1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)),
                    $sformatf("rand d%0d #%0d", d, i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
